lu_serial_driver: RTL and testbench

LU_SERIAL_DRIVER -- requirements
Module: lu_serial_driver

---
 rtl/lu_serial_driver_pkg.sv | 30 +++
 rtl/lu_ser_shreg.sv | 50 +++++
 rtl/lu_serial_driver.sv | 172 +++++++++++++++++
 tb/tb_lu_serial_driver.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_serial_driver_pkg.sv
// ----------------------------------------------------------------------------
// lu_serial_driver_pkg
// Shared definitions for the serial logic-unit driver.
//   state_t  : FSM state encoding (IDLE, RUN, DONE)
//   OP_*     : operation codes; op[1] selects AND/NAND (1) or OR/NOR (0),
//              op[0] selects the inverted gate.
//   op_group / op_gate : decode an op code into the logic-unit select lines.
// ----------------------------------------------------------------------------
package lu_serial_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    function automatic logic op_group(input logic [1:0] op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

    function automatic logic op_gate(input logic [1:0] op);
        return (op == OP_NOR) || (op == OP_NAND);
    endfunction

endpackage

// File: rtl/lu_ser_shreg.sv
// ----------------------------------------------------------------------------
// lu_ser_shreg
// Loadable right-shift register. Load has priority over shift; the serial
// input enters at the MSB so the LSB is the next bit out.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears the register
//   load_i  : parallel load from data_i
//   shift_i : shift right by one, ser_i into the MSB
//   data_i  : parallel load value
//   ser_i   : serial input bit
//   data_o  : current register contents
// ----------------------------------------------------------------------------
module lu_ser_shreg
    import lu_serial_driver_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = {ser_i, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/lu_serial_driver.sv
// ----------------------------------------------------------------------------
// lu_serial_driver
// Drives an external 1-bit logic unit bit-serially: operands A and B are
// latched on start, presented LSB-first on a_bit/b_bit for WIDTH cycles,
// and the unit's combinational answer s_bit is shifted back into a capture
// register that becomes result.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : request an operation (accepted only in IDLE)
//   op_a, op_b          : operands
//   op                  : op[1] group (1 AND/NAND, 0 OR/NOR), op[0] invert
//   a_bit, b_bit        : serial operand bits to the logic unit (0 outside RUN)
//   sel_gate, sel_group : latched op[0] / op[1] to the logic unit
//   s_bit               : logic unit result bit, same cycle
//   busy                : operation in progress (RUN or DONE)
//   done                : one-cycle pulse when result is updated
//   result              : last completed result
//   result_par          : XOR of result, only when LU_SERIAL_DRIVER_PARITY_EN
//                         is defined
// ----------------------------------------------------------------------------
module lu_serial_driver
    import lu_serial_driver_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op,
    output logic             a_bit,
    output logic             b_bit,
    output logic             sel_gate,
    output logic             sel_group,
    input  logic             s_bit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef LU_SERIAL_DRIVER_PARITY_EN
    ,
    output logic             result_par
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             sel_gate_q;
    logic             sel_group_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;

    logic             accept;
    logic             running;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] cap_sh;

    assign accept  = (state_q == ST_IDLE) && start;
    assign running = (state_q == ST_RUN);

    lu_ser_shreg #(.WIDTH(WIDTH)) u_shreg_a (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (accept),
        .shift_i (running),
        .data_i  (op_a),
        .ser_i   (1'b0),
        .data_o  (a_sh)
    );

    lu_ser_shreg #(.WIDTH(WIDTH)) u_shreg_b (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (accept),
        .shift_i (running),
        .data_i  (op_b),
        .ser_i   (1'b0),
        .data_o  (b_sh)
    );

    lu_ser_shreg #(.WIDTH(WIDTH)) u_shreg_cap (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (accept),
        .shift_i (running),
        .data_i  ('0),
        .ser_i   (s_bit),
        .data_o  (cap_sh)
    );

    // Operand bits beyond the LSB only reach the logic unit by shifting, and
    // the oldest capture bit is dropped when the final bit is merged in.
    logic unused_sh_bits;
    assign unused_sh_bits = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1], cap_sh[0]};

    // The last s_bit is merged here so result is complete on the same edge
    // the capture register takes its final shift.
    assign result_d = {s_bit, cap_sh[WIDTH-1:1]};

`ifdef LU_SERIAL_DRIVER_PARITY_EN
    logic par_q;
`else
    // Parity output absent in this build.
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_gate_q  <= 1'b0;
            sel_group_q <= 1'b0;
            result_q    <= '0;
`ifdef LU_SERIAL_DRIVER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        sel_gate_q  <= op_gate(op);
                        sel_group_q <= op_group(op);
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= result_d;
`ifdef LU_SERIAL_DRIVER_PARITY_EN
                        par_q    <= ^result_d;
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_bit     = running & a_sh[0];
    assign b_bit     = running & b_sh[0];
    assign sel_gate  = sel_gate_q;
    assign sel_group = sel_group_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
`ifdef LU_SERIAL_DRIVER_PARITY_EN
    assign result_par = par_q;
`endif

endmodule

// File: tb/tb_lu_serial_driver.sv
// ----------------------------------------------------------------------------
// tb_lu_serial_driver
// Bench for lu_serial_driver with a behavioural 1-bit logic unit closing the
// a_bit/b_bit/sel_* -> s_bit loop and a word-level reference model.
// Cycle numbering: the cycle in which start is accepted is cycle 0; the
// first RUN cycle is cycle 1, so done appears in cycle WIDTH+1.
// ----------------------------------------------------------------------------
module tb_lu_serial_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   op;
    logic         a_bit;
    logic         b_bit;
    logic         sel_gate;
    logic         sel_group;
    logic         s_bit;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef LU_SERIAL_DRIVER_PARITY_EN
    logic         result_par;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    // Behavioural external 1-bit logic unit.
    assign s_bit = sel_group ? ((a_bit & b_bit) ^ sel_gate)
                             : ((a_bit | b_bit) ^ sel_gate);

    lu_serial_driver #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .op         (op),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .sel_gate   (sel_gate),
        .sel_group  (sel_group),
        .s_bit      (s_bit),
        .busy       (busy),
        .done       (done),
        .result     (result)
`ifdef LU_SERIAL_DRIVER_PARITY_EN
        ,
        .result_par (result_par)
`endif
    );

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [1:0]   o);
        logic [W-1:0] r;
        r = o[1] ? (a & b) : (a | b);
        if (o[0]) r = ~r;
        return r;
    endfunction

    // Runs one operation from IDLE and reports what was observed; inputs are
    // scrambled every cycle after acceptance.
    task automatic drive_op(input  logic [W-1:0] a,
                            input  logic [W-1:0] b,
                            input  logic [1:0]   o,
                            output int           done_cyc,
                            output int           dones,
                            output logic [W-1:0] res,
                            output bit           bits_ok,
                            output bit           busy_ok);
        op_a  = a;
        op_b  = b;
        op    = o;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        done_cyc = -1;
        dones    = 0;
        res      = '0;
        bits_ok  = 1'b1;
        busy_ok  = 1'b1;
        for (int c = 1; c <= W + 3; c++) begin
            if (c <= W) begin
                if (a_bit !== a[c-1] || b_bit !== b[c-1]) bits_ok = 1'b0;
            end else if (a_bit !== 1'b0 || b_bit !== 1'b0) begin
                bits_ok = 1'b0;
            end
            if (busy !== (c <= W + 1)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    res      = result;
                end
            end
            op_a = W'($urandom);
            op_b = W'($urandom);
            op   = 2'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int dc, dn;
        logic [W-1:0] r;
        bit bo, uo;
        drive_op(8'hF0, 8'hCC, 2'b11, dc, dn, r, bo, uo);
        reset = 1'b1;
        start = 1'b1;
        op    = 2'b11;
        @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({busy, done, a_bit, b_bit, sel_gate, sel_group} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b, want 000000",
                     {busy, done, a_bit, b_bit, sel_gate, sel_group});
        end else pass_cnt++;
        chk_cnt++;
        if (result !== '0) $display("FAIL reset_result: got %h, want 00", result);
        else pass_cnt++;
`ifdef LU_SERIAL_DRIVER_PARITY_EN
        chk_cnt++;
        if (result_par !== 1'b0) $display("FAIL reset_par: got %b, want 0", result_par);
        else pass_cnt++;
`endif
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_over_start: busy %b, want 0", busy);
        else pass_cnt++;
    endtask

    task automatic check_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] o, input logic [W-1:0] exp);
        int dc, dn;
        logic [W-1:0] r;
        bit bo, uo;
        drive_op(a, b, o, dc, dn, r, bo, uo);
        chk_cnt++;
        if (r !== exp) $display("FAIL op_result op=%b a=%h b=%h: got %h, want %h", o, a, b, r, exp);
        else pass_cnt++;
        chk_cnt++;
        if (dc !== W + 1) $display("FAIL op_latency op=%b: done cycle %0d, want %0d", o, dc, W + 1);
        else pass_cnt++;
        chk_cnt++;
        if (dn !== 1) $display("FAIL op_done_count op=%b: got %0d, want 1", o, dn);
        else pass_cnt++;
        chk_cnt++;
        if (!bo) $display("FAIL op_serial_bits op=%b: got mismatch, want LSB-first operands", o);
        else pass_cnt++;
        chk_cnt++;
        if (!uo) $display("FAIL op_busy op=%b: got wrong profile, want high cycles 1..%0d", o, W + 1);
        else pass_cnt++;
        chk_cnt++;
        if ({sel_group, sel_gate} !== o) $display("FAIL op_sel: got %b, want %b", {sel_group, sel_gate}, o);
        else pass_cnt++;
        chk_cnt++;
        if (result !== exp) $display("FAIL op_hold: got %h, want %h", result, exp);
        else pass_cnt++;
`ifdef LU_SERIAL_DRIVER_PARITY_EN
        chk_cnt++;
        if (result_par !== ^exp) $display("FAIL op_par: got %b, want %b", result_par, ^exp);
        else pass_cnt++;
`endif
    endtask

    task automatic test_ops;
        logic [W-1:0] exp_tab [4];
        logic [1:0]   op_tab  [4];
        logic [W-1:0] a, b;
        logic [1:0]   o;
        exp_tab = '{8'hC0, 8'h3F, 8'hFC, 8'h03};
        op_tab  = '{2'b10, 2'b11, 2'b00, 2'b01};
        for (int i = 0; i < 4; i++) check_op(8'hF0, 8'hCC, op_tab[i], exp_tab[i]);
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            o = 2'($urandom);
            check_op(a, b, o, ref_op(a, b, o));
        end
    endtask

    task automatic test_ignore_start;
        logic [W-1:0] a1, b1, exp;
        logic [1:0]   o1;
        int dones;
        bit busy_ok;
        a1  = W'($urandom);
        b1  = W'($urandom);
        o1  = 2'($urandom);
        exp = ref_op(a1, b1, o1);
        op_a  = a1;
        op_b  = b1;
        op    = o1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        dones   = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= W + 4; c++) begin
            if (done === 1'b1) dones++;
            if (busy !== (c <= W + 1)) busy_ok = 1'b0;
            if (c == 3 || c == W + 1) begin
                start = 1'b1;
                op_a  = ~a1;
                op_b  = ~b1;
                op    = ~o1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk_cnt++;
        if (dones !== 1) $display("FAIL ign_done_count: got %0d, want 1", dones);
        else pass_cnt++;
        chk_cnt++;
        if (!busy_ok) $display("FAIL ign_busy: got wrong profile, want high cycles 1..%0d only", W + 1);
        else pass_cnt++;
        chk_cnt++;
        if (result !== exp) $display("FAIL ign_result: got %h, want %h", result, exp);
        else pass_cnt++;
        chk_cnt++;
        if ({sel_group, sel_gate} !== o1) $display("FAIL ign_sel: got %b, want %b", {sel_group, sel_gate}, o1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int dc, dn, late_dones;
        logic [W-1:0] r;
        bit bo, uo;
        drive_op(8'hF0, 8'hCC, 2'b00, dc, dn, r, bo, uo);
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        op    = 2'($urandom);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 4; c++) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL mid_reset_ctrl: got %b, want 00", {busy, done});
        else pass_cnt++;
        chk_cnt++;
        if (result !== '0) $display("FAIL mid_reset_result: got %h, want 00", result);
        else pass_cnt++;
        late_dones = 0;
        for (int c = 0; c < W + 4; c++) begin
            if (done === 1'b1 || busy === 1'b1) late_dones++;
            @(negedge clk);
        end
        chk_cnt++;
        if (late_dones !== 0) $display("FAIL mid_reset_abort: got %0d active cycles, want 0", late_dones);
        else pass_cnt++;
        check_op(8'h5A, 8'h3C, 2'b10, 8'h18);
    endtask

    task automatic test_zero_par;
        check_op(8'hFF, 8'h00, 2'b10, 8'h00);
    endtask

    task automatic test_back_to_back;
        localparam int N = 5;
        logic [W-1:0] q [$];
        logic [W-1:0] exp;
        int dones, last, c;
        op_a = W'($urandom);
        op_b = W'($urandom);
        op   = 2'($urandom);
        q.push_back(ref_op(op_a, op_b, op));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c     = 1;
        dones = 0;
        last  = -1;
        while (dones < N && c <= N * (W + 2) + 10) begin
            if (done === 1'b1) begin
                dones++;
                exp = q.pop_front();
                chk_cnt++;
                if (result !== exp) $display("FAIL b2b_result #%0d: got %h, want %h", dones, result, exp);
                else pass_cnt++;
                chk_cnt++;
                if ((last < 0 && c !== W + 1) || (last >= 0 && c - last !== W + 2)) begin
                    $display("FAIL b2b_spacing #%0d: got cycle %0d (prev %0d), want period %0d",
                             dones, c, last, W + 2);
                end else pass_cnt++;
                last = c;
                if (dones < N) begin
                    op_a = W'($urandom);
                    op_b = W'($urandom);
                    op   = 2'($urandom);
                    q.push_back(ref_op(op_a, op_b, op));
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk_cnt++;
        if (dones !== N) $display("FAIL b2b_count: got %0d, want %0d", dones, N);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        op    = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_ops;
        test_ignore_start;
        test_reset_mid;
        test_zero_par;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
